// File: rtl/redun_mont_pkg.sv
// Shared types and constants for the redundant-form Montgomery datapath.
// Holds the modulus P, the redundant/canonical word types and the collapse FSM encoding.
package redun_mont_pkg;

  localparam int WRD_BITS         = 32;
  localparam int NUM_WRDS         = 33;
  localparam int DAT_BITS         = WRD_BITS * NUM_WRDS;
  localparam int WRDS_PER_CYC_DEF = 3;

  typedef logic [WRD_BITS-1:0]               fe_wrd_t;
  typedef logic [DAT_BITS-1:0]               fe_t;
  typedef logic [DAT_BITS:0]                 fe_wide_t;
  typedef logic [NUM_WRDS-1:0][WRD_BITS:0]   redun0_t;

  typedef enum logic [1:0] {
    IDLE,
    PROP,
    OUT
  } collapse_state_t;

  // 1024-bit odd modulus; the top word of the field element stays zero for canonical values
  localparam fe_t P = (fe_t'(1) << 1024) - fe_t'(105);

  function automatic fe_wrd_t p_wrd(input int unsigned i);
    return fe_wrd_t'(P >> (WRD_BITS * i));
  endfunction

  // Bit WRD_BITS of word i carries weight 2^(WRD_BITS*(i+1))
  function automatic fe_wide_t from_redun(input redun0_t x);
    fe_wide_t acc;
    acc = '0;
    for (int i = 0; i < NUM_WRDS; i++) begin
      acc = acc + (fe_wide_t'(x[i][WRD_BITS-1:0]) << (WRD_BITS * i));
      acc = acc + (fe_wide_t'(x[i][WRD_BITS]) << (WRD_BITS * (i + 1)));
    end
    return acc;
  endfunction

  function automatic redun0_t to_redun(input fe_t v);
    redun0_t r;
    r = '0;
    for (int i = 0; i < NUM_WRDS; i++) begin
      r[i] = {1'b0, fe_wrd_t'(v >> (WRD_BITS * i))};
    end
    return r;
  endfunction

endpackage

// File: rtl/redun_mont_collapse_chunk.sv
// Combinational carry (and optional borrow) ripple across one chunk of words.
// Borrow/d logic exists only when REDUN_MONT_COLLAPSE_FINAL_SUB_EN is defined.
module redun_mont_collapse_chunk
  import redun_mont_pkg::*;
#(
  parameter int WRDS = WRDS_PER_CYC_DEF
) (
  input  logic [WRDS-1:0][WRD_BITS:0]   wrd,
  input  logic                          hi_in,
  input  logic                          c_in,
`ifdef REDUN_MONT_COLLAPSE_FINAL_SUB_EN
  input  logic [WRDS-1:0][WRD_BITS-1:0] p,
  input  logic                          b_in,
  output logic [WRDS-1:0][WRD_BITS-1:0] d,
  output logic                          b_out,
`endif
  output logic [WRDS-1:0][WRD_BITS-1:0] r,
  output logic                          c_out,
  output logic                          hi_out
);

  logic                c;
  logic                hi;
  logic [WRD_BITS:0]   sum;

  // hi is the overflow bit of the previous word, which lands on this word's LSB
  always_comb begin
    c   = c_in;
    hi  = hi_in;
    sum = '0;
    r   = '0;
    for (int j = 0; j < WRDS; j++) begin
      sum  = {1'b0, wrd[j][WRD_BITS-1:0]} + (WRD_BITS+1)'(hi) + (WRD_BITS+1)'(c);
      r[j] = sum[WRD_BITS-1:0];
      c    = sum[WRD_BITS];
      hi   = wrd[j][WRD_BITS];
    end
    c_out  = c;
    hi_out = hi;
  end

`ifdef REDUN_MONT_COLLAPSE_FINAL_SUB_EN
  logic              b;
  logic [WRD_BITS:0] diff;

  always_comb begin
    b    = b_in;
    diff = '0;
    d    = '0;
    for (int j = 0; j < WRDS; j++) begin
      diff = {1'b0, r[j]} - {1'b0, p[j]} - (WRD_BITS+1)'(b);
      d[j] = diff[WRD_BITS-1:0];
      b    = diff[WRD_BITS];
    end
    b_out = b;
  end
`endif

endmodule

// File: rtl/redun_mont_collapse.sv
// Collapses a redundant Montgomery result to canonical form, WRDS_PER_CYC words per cycle.
// Define REDUN_MONT_COLLAPSE_FINAL_SUB_EN to add a final conditional subtraction of P.
module redun_mont_collapse
  import redun_mont_pkg::*;
#(
  parameter int WRDS_PER_CYC = WRDS_PER_CYC_DEF
) (
  input  logic    i_clk,
  input  logic    i_rst_n,
  input  redun0_t i_dat,
  input  logic    i_val,
  output logic    o_rdy,
  output fe_t     o_dat,
  output logic    o_ovf,
  output logic    o_val,
  input  logic    i_rdy
);

  localparam int NUM_CHUNKS = NUM_WRDS / WRDS_PER_CYC;
  localparam int CNT_W      = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
  localparam int IDX_W      = $clog2(NUM_WRDS);
  localparam logic [CNT_W-1:0] LAST_CHUNK = CNT_W'(NUM_CHUNKS - 1);

  if (!(WRDS_PER_CYC == 1 || WRDS_PER_CYC == 3 ||
        WRDS_PER_CYC == 11 || WRDS_PER_CYC == 33)) begin : g_bad_wrds_per_cyc
    $error("redun_mont_collapse: WRDS_PER_CYC must be 1, 3, 11 or 33");
  end

  collapse_state_t                          state_q;
  redun0_t                                  dat_q;
  logic [NUM_WRDS-1:0][WRD_BITS-1:0]        r_q;
  logic [CNT_W-1:0]                         cnt_q;
  logic                                     c_q;
  logic                                     hi_q;

  logic [WRDS_PER_CYC-1:0][IDX_W-1:0]       chunk_idx;
  logic [WRDS_PER_CYC-1:0][WRD_BITS:0]      chunk_wrd;
  logic [WRDS_PER_CYC-1:0][WRD_BITS-1:0]    chunk_r;
  logic [NUM_WRDS-1:0][WRD_BITS-1:0]        r_full;
  logic                                     c_out;
  logic                                     hi_out;
  logic                                     ovf_now;

  always_comb begin
    chunk_idx = '0;
    chunk_wrd = '0;
    for (int j = 0; j < WRDS_PER_CYC; j++) begin
      chunk_idx[j] = IDX_W'(int'(cnt_q) * WRDS_PER_CYC + j);
      chunk_wrd[j] = dat_q[chunk_idx[j]];
    end
  end

  // Result so far with the chunk being resolved this cycle merged in
  always_comb begin
    r_full = r_q;
    for (int j = 0; j < WRDS_PER_CYC; j++) begin
      r_full[chunk_idx[j]] = chunk_r[j];
    end
  end

  assign ovf_now = c_out | hi_out;

`ifdef REDUN_MONT_COLLAPSE_FINAL_SUB_EN
  logic [NUM_WRDS-1:0][WRD_BITS-1:0]        d_q;
  logic                                     b_q;
  logic [WRDS_PER_CYC-1:0][WRD_BITS-1:0]    chunk_p;
  logic [WRDS_PER_CYC-1:0][WRD_BITS-1:0]    chunk_d;
  logic [NUM_WRDS-1:0][WRD_BITS-1:0]        d_full;
  logic                                     b_out;
  fe_t                                      fin_dat;

  always_comb begin
    chunk_p = '0;
    d_full  = d_q;
    for (int j = 0; j < WRDS_PER_CYC; j++) begin
      chunk_p[j]           = p_wrd(32'(chunk_idx[j]));
      d_full[chunk_idx[j]] = chunk_d[j];
    end
  end

  // No final borrow means r >= P; an overflow means r is certainly >= P
  assign fin_dat = (ovf_now || !b_out) ? fe_t'(d_full) : fe_t'(r_full);
`else
  fe_t fin_dat;
  assign fin_dat = fe_t'(r_full);
`endif

  redun_mont_collapse_chunk #(
    .WRDS   (WRDS_PER_CYC)
  ) u_chunk (
    .wrd    (chunk_wrd),
    .hi_in  (hi_q),
    .c_in   (c_q),
`ifdef REDUN_MONT_COLLAPSE_FINAL_SUB_EN
    .p      (chunk_p),
    .b_in   (b_q),
    .d      (chunk_d),
    .b_out  (b_out),
`endif
    .r      (chunk_r),
    .c_out  (c_out),
    .hi_out (hi_out)
  );

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      o_rdy   <= 1'b0;
      o_val   <= 1'b0;
      o_dat   <= '0;
      o_ovf   <= 1'b0;
      cnt_q   <= '0;
      c_q     <= 1'b0;
      hi_q    <= 1'b0;
`ifdef REDUN_MONT_COLLAPSE_FINAL_SUB_EN
      b_q     <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          o_rdy <= 1'b1;
          if (i_val && o_rdy) begin
            dat_q   <= i_dat;
            cnt_q   <= '0;
            c_q     <= 1'b0;
            hi_q    <= 1'b0;
`ifdef REDUN_MONT_COLLAPSE_FINAL_SUB_EN
            b_q     <= 1'b0;
`endif
            o_rdy   <= 1'b0;
            state_q <= PROP;
          end
        end
        PROP: begin
          r_q  <= r_full;
          c_q  <= c_out;
          hi_q <= hi_out;
`ifdef REDUN_MONT_COLLAPSE_FINAL_SUB_EN
          d_q  <= d_full;
          b_q  <= b_out;
`endif
          if (cnt_q == LAST_CHUNK) begin
            o_dat   <= fin_dat;
            o_ovf   <= ovf_now;
            o_val   <= 1'b1;
            state_q <= OUT;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        OUT: begin
          if (i_rdy) begin
            o_val   <= 1'b0;
            o_rdy   <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_redun_mont_collapse.sv
// Scoreboard bench for redun_mont_collapse: directed vectors, stall, abort and random traffic.
// Expected values follow REDUN_MONT_COLLAPSE_FINAL_SUB_EN when it is defined.
module tb_redun_mont_collapse;
  import redun_mont_pkg::*;

  localparam int LATENCY = 12;

  typedef struct {
    fe_t  dat;
    logic ovf;
  } exp_t;

  logic    clk = 1'b0;
  logic    rst_n = 1'b0;
  redun0_t i_dat = '0;
  logic    i_val = 1'b0;
  logic    o_rdy;
  fe_t     o_dat;
  logic    o_ovf;
  logic    o_val;
  logic    i_rdy = 1'b1;

  exp_t    sb[$];
  int      total = 0;
  int      bad = 0;
  int      cyc = 0;
  int      acc_cyc = 0;
  logic    lat_armed = 1'b0;
  logic    prev_val = 1'b0;
  logic    rdy_rand = 1'b0;

  redun_mont_collapse dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_dat   (i_dat),
    .i_val   (i_val),
    .o_rdy   (o_rdy),
    .o_dat   (o_dat),
    .o_ovf   (o_ovf),
    .o_val   (o_val),
    .i_rdy   (i_rdy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input fe_wide_t act, input fe_wide_t exp);
    int w;
    total++;
    if (act !== exp) begin
      bad++;
      w = 0;
      for (int i = NUM_WRDS; i >= 0; i--)
        if (fe_wrd_t'(act >> (WRD_BITS * i)) !== fe_wrd_t'(exp >> (WRD_BITS * i))) w = i;
      $display("[TB] FAIL %s: word %0d got %h want %h", name, w,
               fe_wrd_t'(act >> (WRD_BITS * w)), fe_wrd_t'(exp >> (WRD_BITS * w)));
    end
  endtask

  function automatic exp_t expOf(input redun0_t v);
    exp_t     e;
    fe_wide_t w;
    w     = from_redun(v);
    e.ovf = w[DAT_BITS];
`ifdef REDUN_MONT_COLLAPSE_FINAL_SUB_EN
    e.dat = (w >= fe_wide_t'(P)) ? fe_t'(w - fe_wide_t'(P)) : fe_t'(w);
`else
    e.dat = fe_t'(w);
`endif
    return e;
  endfunction

  function automatic redun0_t randRedun(input int n);
    redun0_t v;
    for (int i = 0; i < NUM_WRDS; i++) begin
      v[i] = {1'($urandom_range(0, 1)), 32'($urandom)};
      if (n % 8 == 0) v[i] = {1'b0, 32'hFFFF_FFFF};
    end
    return v;
  endfunction

  // Present one value, wait for the accept, then scramble i_dat
  task automatic applyStimulus(input redun0_t v, input fe_t ed, input logic eo);
    exp_t e;
    int   n;
    @(posedge clk); #1;
    i_val = 1'b1;
    i_dat = v;
    n = 0;
    while (!o_rdy && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (!o_rdy) begin
      checkOutput("accept_timeout", 0, 1);
      i_val = 1'b0;
    end else begin
      e.dat = ed;
      e.ovf = eo;
      sb.push_back(e);
      acc_cyc   = cyc;
      lat_armed = 1'b1;
      @(posedge clk); #1;
      i_val = 1'b0;
      i_dat = randRedun(1);
    end
  endtask

  task automatic waitDrain(input int budget);
    int n;
    n = 0;
    while ((sb.size() != 0 || o_val) && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    if (sb.size() != 0 || o_val) checkOutput("drain_timeout", fe_wide_t'(sb.size()), 0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      prev_val <= 1'b0;
    end else begin
      if (o_val && !prev_val && lat_armed) begin
        checkOutput("latency", fe_wide_t'(cyc - acc_cyc), fe_wide_t'(LATENCY));
        lat_armed = 1'b0;
      end
      if (o_val && i_rdy) begin
        if (sb.size() == 0) begin
          checkOutput("unexpected_output", 1, 0);
        end else begin
          e = sb.pop_front();
          checkOutput("o_dat", fe_wide_t'(o_dat), fe_wide_t'(e.dat));
          checkOutput("o_ovf", fe_wide_t'(o_ovf), fe_wide_t'(e.ovf));
        end
      end
      prev_val <= o_val;
    end
  end

  initial begin
    forever begin
      @(posedge clk); #2;
      if (rdy_rand) i_rdy = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    redun0_t v;
    exp_t    e;
    fe_t     e_one, e_rip, e_p, e_pm1, e_ovf;

    e_one = fe_t'(65'h1_0000_0005);
    e_rip = (fe_t'(1) << 1024) + (fe_t'(1) << 32) - fe_t'(1);
    e_pm1 = P - fe_t'(1);
`ifdef REDUN_MONT_COLLAPSE_FINAL_SUB_EN
    e_rip = e_rip - P;
    e_p   = '0;
    e_ovf = fe_t'(0) - P;
`else
    e_p   = P;
    e_ovf = '0;
`endif

    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_o_rdy", fe_wide_t'(o_rdy), 0);
    checkOutput("rst_o_val", fe_wide_t'(o_val), 0);
    checkOutput("rst_o_dat", fe_wide_t'(o_dat), 0);
    checkOutput("rst_o_ovf", fe_wide_t'(o_ovf), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    checkOutput("rdy_after_rst", fe_wide_t'(o_rdy), 1);

    v = '0; v[0] = 33'h1_0000_0005;
    applyStimulus(v, e_one, 1'b0);
    waitDrain(100);

    v[0] = 33'h1_FFFF_FFFF;
    for (int i = 1; i < 32; i++) v[i] = 33'h0_FFFF_FFFF;
    v[32] = '0;
    applyStimulus(v, e_rip, 1'b0);
    waitDrain(100);

    applyStimulus(to_redun(P), e_p, 1'b0);
    waitDrain(100);
    applyStimulus(to_redun(P - fe_t'(1)), e_pm1, 1'b0);
    waitDrain(100);

    v = '0; v[32] = 33'h1_0000_0000;
    applyStimulus(v, e_ovf, 1'b1);
    waitDrain(100);

    // Stall in OUT with a competing i_val that must be dropped
    i_rdy = 1'b0;
    v = '0; v[0] = 33'h1_0000_0005;
    applyStimulus(v, e_one, 1'b0);
    for (int n = 0; n < 50 && !o_val; n++) begin
      @(posedge clk); #1;
    end
    for (int k = 0; k < 5; k++) begin
      i_val = 1'b1;
      i_dat = randRedun(3);
      checkOutput("hold_o_dat", fe_wide_t'(o_dat), fe_wide_t'(e_one));
      checkOutput("hold_o_val", fe_wide_t'(o_val), 1);
      checkOutput("hold_o_rdy", fe_wide_t'(o_rdy), 0);
      @(posedge clk); #1;
    end
    i_val = 1'b0;
    i_rdy = 1'b1;
    waitDrain(20);
    v = '0; v[1] = 33'h1_8000_0000;
    e = expOf(v);
    applyStimulus(v, e.dat, e.ovf);
    waitDrain(100);

    // Abort mid-propagation at chunk 5
    applyStimulus(randRedun(2), '0, 1'b0);
    repeat (5) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    @(posedge clk); #1;
    sb.delete();
    lat_armed = 1'b0;
    checkOutput("abort_o_rdy", fe_wide_t'(o_rdy), 0);
    checkOutput("abort_o_val", fe_wide_t'(o_val), 0);
    checkOutput("abort_o_dat", fe_wide_t'(o_dat), 0);
    checkOutput("abort_o_ovf", fe_wide_t'(o_ovf), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    checkOutput("abort_rdy_back", fe_wide_t'(o_rdy), 1);
    v = '0; v[0] = 33'h1_0000_0005;
    applyStimulus(v, e_one, 1'b0);
    waitDrain(100);

    rdy_rand = 1'b1;
    for (int n = 0; n < 2000; n++) begin
      v = randRedun(n);
      e = expOf(v);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      applyStimulus(v, e.dat, e.ovf);
    end
    waitDrain(400);
    rdy_rand = 1'b0;
    #3 i_rdy = 1'b1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
